// File: rtl/microseq_pkg.sv
// microseq_pkg: shared definitions for the microprogrammed control sequencer.
// Holds the microcode word field positions, width derivation helpers, the
// idle control word and the named bit indices of the datapath control word.
package microseq_pkg;

  // Number of bits needed to select one of flag_w condition flags (at least 1).
  function automatic int fsel_width(input int flag_w);
    return (flag_w <= 2) ? 1 : $clog2(flag_w);
  endfunction

  // Full microcode word width: {end, br_en, br_sel, br_tgt, ctrl}.
  function automatic int uword_width(input int ctrl_w, input int step_w, input int flag_w);
    return ctrl_w + step_w + fsel_width(flag_w) + 2;
  endfunction

  // Field positions inside a microcode word, LSB upwards.
  function automatic int brtgt_lsb(input int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int brsel_lsb(input int ctrl_w, input int step_w);
    return ctrl_w + step_w;
  endfunction

  function automatic int bren_bit(input int ctrl_w, input int step_w, input int flag_w);
    return brsel_lsb(ctrl_w, step_w) + fsel_width(flag_w);
  endfunction

  function automatic int end_bit(input int ctrl_w, input int step_w, input int flag_w);
    return bren_bit(ctrl_w, step_w, flag_w) + 1;
  endfunction

  // Default geometry of the accumulator CPU sequencer.
  localparam int DEF_OPCODE_W = 4;
  localparam int DEF_STEP_W   = 3;
  localparam int DEF_CTRL_W   = 16;
  localparam int DEF_FLAG_W   = 2;

  // Field positions for the default geometry.
  localparam int BRTGT_LSB = brtgt_lsb(DEF_CTRL_W);
  localparam int BRSEL_LSB = brsel_lsb(DEF_CTRL_W, DEF_STEP_W);
  localparam int BREN_BIT  = bren_bit(DEF_CTRL_W, DEF_STEP_W, DEF_FLAG_W);
  localparam int END_BIT   = end_bit(DEF_CTRL_W, DEF_STEP_W, DEF_FLAG_W);

  // Idle control word: every active-low strobe is held inactive.
  localparam logic [DEF_CTRL_W-1:0] CTRL_IDLE_DEFAULT = 16'h6E3E;

  // Named control-word bit indices (the _N entries are active-low).
  localparam int CB_ADD_SUB      = 0;   // ALU mode: 1 = subtract
  localparam int CB_LOAD_A_N     = 1;
  localparam int CB_LOAD_B_N     = 2;
  localparam int CB_LOAD_IR_N    = 3;
  localparam int CB_LOAD_MAR_N   = 4;
  localparam int CB_LOAD_OUT_N   = 5;
  localparam int CB_EN_SRC_LSB   = 6;   // bus enable-source field
  localparam int CB_EN_SRC_W     = 3;
  localparam int CB_PC_LOAD_N    = 9;
  localparam int CB_PC_CLR_N     = 10;
  localparam int CB_RAM_RD_N     = 11;
  localparam int CB_PC_INC       = 12;
  localparam int CB_RAM_WR_N     = 13;
  localparam int CB_CNT_RST_N    = 14;

  // How the step counter moves on a given cycle.
  typedef enum logic [1:0] {
    STEP_HOLD   = 2'd0,
    STEP_CLEAR  = 2'd1,
    STEP_BRANCH = 2'd2,
    STEP_INC    = 2'd3
  } step_act_e;

endpackage

// File: rtl/microcode_store.sv
// microcode_store: writable control store, 2^AW words of DW bits.
// Synchronous write port, combinational read port. A read of the address
// being written in the same cycle returns the old word. Contents are never
// reset, so they survive a sequencer reset.
module microcode_store #(
  parameter int AW = 7,
  parameter int DW = 22
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Write port: the new word lands at the rising edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: microprogrammed control sequencer for the accumulator
// CPU datapath. Reads {opcode, step} from a writable control store and
// registers the control word, the step counter and an end-of-instruction
// pulse. Optional feature macro: MICROSEQ_BRANCH_EN enables flag-conditional
// step branching; when undefined the branch fields are stored but ignored and
// the step only increments or terminates.
module microcode_sequencer
  import microseq_pkg::*;
#(
  parameter int                 OPCODE_W  = 4,
  parameter int                 STEP_W    = 3,
  parameter int                 CTRL_W    = 16,
  parameter int                 FLAG_W    = 2,
  parameter logic [CTRL_W-1:0]  CTRL_IDLE = CTRL_W'(CTRL_IDLE_DEFAULT)
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic [OPCODE_W-1:0]                         instruction_register,
  input  logic [FLAG_W-1:0]                           flags,
  input  logic                                        halt,
  input  logic                                        ucode_we,
  input  logic [OPCODE_W+STEP_W-1:0]                  ucode_waddr,
  input  logic [uword_width(CTRL_W, STEP_W, FLAG_W)-1:0] ucode_wdata,
  output logic [CTRL_W-1:0]                           ctrl_word,
  output logic [STEP_W-1:0]                           step,
  output logic                                        instr_done
);

  localparam int FSEL_W  = fsel_width(FLAG_W);
  localparam int UW      = uword_width(CTRL_W, STEP_W, FLAG_W);
  localparam int AW      = OPCODE_W + STEP_W;
  localparam int TGT_L   = brtgt_lsb(CTRL_W);
  localparam int SEL_L   = brsel_lsb(CTRL_W, STEP_W);
  localparam int BREN_B  = bren_bit(CTRL_W, STEP_W, FLAG_W);
  localparam int END_B   = end_bit(CTRL_W, STEP_W, FLAG_W);
  localparam logic [STEP_W-1:0] STEP_LAST = '1;

  logic [STEP_W-1:0] step_q, step_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              done_q, done_d;

  logic [AW-1:0]     rd_addr;
  logic [UW-1:0]     uword;

  logic              f_end;
  logic              f_bren;
  logic [FSEL_W-1:0] f_brsel;
  logic [STEP_W-1:0] f_brtgt;
  logic [CTRL_W-1:0] f_ctrl;

  logic              terminal;
  logic              br_taken;
  step_act_e         act;

  assign rd_addr = {instruction_register, step_q};

  microcode_store #(
    .AW (AW),
    .DW (UW)
  ) u_store (
    .clk     (clk),
    .we_i    (ucode_we),
    .waddr_i (ucode_waddr),
    .wdata_i (ucode_wdata),
    .raddr_i (rd_addr),
    .rdata_o (uword)
  );

  // Unpack the current microcode word.
  assign f_end   = uword[END_B];
  assign f_bren  = uword[BREN_B];
  assign f_brsel = uword[SEL_L +: FSEL_W];
  assign f_brtgt = uword[TGT_L +: STEP_W];
  assign f_ctrl  = uword[CTRL_W-1:0];

  // The last step of the counter always terminates, even without an end bit.
  assign terminal = f_end | (step_q == STEP_LAST);

`ifdef MICROSEQ_BRANCH_EN
  logic [(2**FSEL_W)-1:0] flags_ext;

  // Pad the flag vector so every br_sel encoding indexes a defined bit.
  always_comb begin
    flags_ext = '0;
    flags_ext[FLAG_W-1:0] = flags;
  end

  assign br_taken = f_bren & flags_ext[f_brsel];
`else
  logic unused_branch;

  assign unused_branch = ^{f_bren, f_brsel, f_brtgt, flags};
  assign br_taken      = 1'b0;
`endif

  // Next-step selection: halt beats termination, termination beats branch.
  always_comb begin
    act = STEP_INC;
    if (halt) begin
      act = STEP_HOLD;
    end else if (terminal) begin
      act = STEP_CLEAR;
    end else if (br_taken) begin
      act = STEP_BRANCH;
    end

    step_d = step_q;
    unique case (act)
      STEP_HOLD:   step_d = step_q;
      STEP_CLEAR:  step_d = '0;
      STEP_BRANCH: step_d = f_brtgt;
      STEP_INC:    step_d = step_q + STEP_W'(1);
      default:     step_d = step_q;
    endcase

    ctrl_d = halt ? CTRL_IDLE : f_ctrl;
    done_d = ~halt & terminal;
  end

  // Registered sequencer state; reset forces step 0 and the idle control word.
  always_ff @(posedge clk) begin
    if (rstn) begin
      step_q <= '0;
      ctrl_q <= CTRL_IDLE;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      ctrl_q <= ctrl_d;
      done_q <= done_d;
    end
  end

  assign ctrl_word  = ctrl_q;
  assign step       = step_q;
  assign instr_done = done_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: randomized and directed stimulus against a
// behavioural model of the sequencer; expected outputs are queued per cycle
// and a separate monitor compares them with the DUT on the falling edge.
module tb_microcode_sequencer;

  localparam int OW = 4;
  localparam int SW = 3;
  localparam int CW = 16;
  localparam int FW = 2;
  localparam int UW = 22;
  localparam int AW = 7;
  localparam logic [15:0] IDLE = 16'h6E3E;
`ifdef MICROSEQ_BRANCH_EN
  localparam bit BR_ON = 1'b1;
`else
  localparam bit BR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          halt = 1'b0;
  logic          we = 1'b0;
  logic [OW-1:0] ir = '0;
  logic [FW-1:0] flags = '0;
  logic [AW-1:0] wa = '0;
  logic [UW-1:0] wd = '0;
  logic [CW-1:0] ctrl_word;
  logic [SW-1:0] step;
  logic          instr_done;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .instruction_register (ir),
    .flags                (flags),
    .halt                 (halt),
    .ucode_we             (we),
    .ucode_waddr          (wa),
    .ucode_wdata          (wd),
    .ctrl_word            (ctrl_word),
    .step                 (step),
    .instr_done           (instr_done)
  );

  // Reference model: control store contents as separate fields plus the step.
  bit          m_end   [128];
  bit          m_bren  [128];
  bit          m_brsel [128];
  int          m_tgt   [128];
  logic [15:0] m_ctrl  [128];
  int          m_step = 0;
  bit          m_done = 0;

  logic [19:0] exp_q [$];
  int          phase_q [$];
  int          phase = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [21:0] prog [128];

  function automatic logic [21:0] mk(bit e, bit b, bit s, logic [2:0] t, logic [15:0] c);
    return {e, b, s, t, c};
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [21:0] d);
    m_end[a]   = d[21];
    m_bren[a]  = d[20];
    m_brsel[a] = d[19];
    m_tgt[a]   = int'(d[18:16]);
    m_ctrl[a]  = d[15:0];
  endtask

  // One clock cycle: apply inputs, predict the post-edge outputs, queue them.
  task automatic drive(input bit r, input bit h, input logic [3:0] op, input logic [1:0] fl,
                       input bit w, input logic [6:0] a, input logic [21:0] d);
    int ad;
    int ns;
    logic [15:0] ec;
    bit ed;
    bit last;
    bit tk;
    rstn = r; halt = h; ir = op; flags = fl; we = w; wa = a; wd = d;
    ad = int'(op) * 8 + m_step;
    if (r) begin
      ns = 0; ec = IDLE; ed = 0;
    end else if (h) begin
      ns = m_step; ec = IDLE; ed = 0;
    end else begin
      last = m_end[ad] || (m_step == 7);
      tk   = BR_ON && m_bren[ad] && fl[m_brsel[ad]];
      ec   = m_ctrl[ad];
      ed   = last;
      ns   = last ? 0 : (tk ? m_tgt[ad] : m_step + 1);
    end
    if (w) model_write(a, d);
    @(posedge clk);
    exp_q.push_back({ec, 3'(ns), ed});
    phase_q.push_back(phase);
    m_step = ns;
    m_done = ed;
    #1;
  endtask

  task automatic plain(input logic [3:0] op, input logic [1:0] fl);
    drive(0, 0, op, fl, 0, '0, '0);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [1:0] fl);
    int n;
    n = 0;
    do begin
      plain(op, fl);
      n++;
    end while (!m_done && n < 20);
    if (!m_done) begin
      total++; bad++;
      $display("FAIL run_instr op=%0h: got no completion in 20 cycles, want completion", op);
    end
  endtask

  task automatic run_to(input logic [3:0] op, input logic [1:0] fl, input int target);
    int n;
    n = 0;
    while (m_step != target && n < 20) begin
      plain(op, fl);
      n++;
    end
    if (m_step != target) begin
      total++; bad++;
      $display("FAIL run_to op=%0h: got step %0d, want %0d", op, m_step, target);
    end
  endtask

  // Monitor: one expected record per clock, compared away from the active edge.
  logic [19:0] mon_e;
  int          mon_p;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_p = phase_q.pop_front();
      cyc++;
      total++;
      if (ctrl_word !== mon_e[19:4]) begin
        bad++;
        $display("FAIL ctrl_word phase=%0d cyc=%0d got=%h want=%h", mon_p, cyc, ctrl_word, mon_e[19:4]);
      end
      total++;
      if (step !== mon_e[3:1]) begin
        bad++;
        $display("FAIL step phase=%0d cyc=%0d got=%0d want=%0d", mon_p, cyc, step, mon_e[3:1]);
      end
      total++;
      if (instr_done !== mon_e[0]) begin
        bad++;
        $display("FAIL instr_done phase=%0d cyc=%0d got=%b want=%b", mon_p, cyc, instr_done, mon_e[0]);
      end
    end
  end

  initial begin
    // Program image: identical fetch steps, random elsewhere, directed opcodes.
    for (int a = 0; a < 128; a++) begin
      int op;
      int s;
      op = a / 8;
      s  = a % 8;
      if (s == 0)      prog[a] = mk(0, 0, 0, 3'd0, 16'hA5C3);
      else if (s == 1) prog[a] = mk(0, 0, 0, 3'd0, 16'h3C5A);
      else if (op == 1 || op == 2 || op == 3 || op == 5 || op == 7)
        prog[a] = mk(0, 0, 0, 3'd0, 16'($urandom));
      else
        prog[a] = mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 16'($urandom));
      if (op == 1 && s == 4) prog[a] = mk(1, 0, 0, 3'd0, 16'h1444);
      if (op == 2 && s == 6) prog[a] = mk(1, 0, 0, 3'd0, 16'h2666);
      if (op == 7 && s == 3) prog[a] = mk(0, 1, 1, 3'd6, 16'h7333);
      if (op == 5 && s == 2) prog[a] = mk(1, 1, 0, 3'd5, 16'h5222);
    end

    // Load the whole store while reset is held, then three more reset cycles.
    phase = 0;
    for (int a = 0; a < 128; a++) drive(1, 0, 4'h0, 2'b00, 1, 7'(a), prog[a]);
    phase = 1;
    for (int i = 0; i < 3; i++) drive(1, 0, 4'h0, 2'b00, 0, '0, '0);

    // Linear instruction with end on step 4, twice.
    phase = 2;
    run_instr(4'h1, 2'b00);
    run_instr(4'h1, 2'b00);

    // Halt for two cycles at step 2, then resume.
    phase = 3;
    run_to(4'h1, 2'b00, 2);
    drive(0, 1, 4'h1, 2'b11, 0, '0, '0);
    drive(0, 1, 4'h1, 2'b11, 0, '0, '0);
    run_instr(4'h1, 2'b00);

    // Branch at step 3 on flag 1: taken, not taken, other flag only.
    phase = 4;
    run_instr(4'h7, 2'b10);
    run_instr(4'h7, 2'b00);
    run_instr(4'h7, 2'b01);

    // Wrap from the last step without an end bit; end beats a taken branch.
    phase = 5;
    run_instr(4'h3, 2'b11);
    run_instr(4'h5, 2'b11);

    // Write to the address being read this cycle, then revisit it.
    phase = 6;
    run_to(4'h2, 2'b00, 1);
    drive(0, 0, 4'h2, 2'b00, 1, {4'h2, 3'd1}, mk(0, 0, 0, 3'd0, 16'hBEEF));
    run_instr(4'h2, 2'b00);
    run_instr(4'h2, 2'b00);

    // Reset mid-instruction at step 5; store contents survive.
    phase = 7;
    run_to(4'h2, 2'b00, 5);
    drive(1, 0, 4'h2, 2'b00, 0, '0, '0);
    run_instr(4'h2, 2'b00);

    // Random traffic: opcodes, flags, halts, resets and store writes.
    phase = 8;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, 4'($urandom), 2'($urandom),
            $urandom_range(0, 7) == 0, 7'($urandom), 22'($urandom));
    end
    plain(4'h0, 2'b00);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised microprogrammed control sequencer for the accumulator CPU datapath. It generalises the fixed 3-bit step counter and control store to configurable opcode width, step depth and control-word width. It adds a writable microcode store, per-step end-of-instruction, flag-conditional step branching, and a halt/stall input. It sits between the instruction register and the datapath; its registered control word drives bus enables, load strobes, ALU mode, and PC/RAM controls.

## Interface
- `OPCODE_W`, 4: instruction-register opcode width.
- `STEP_W`, 3: step-counter width; there are 2^STEP_W steps per opcode.
- `CTRL_W`, 16: width of the datapath control word.
- `FLAG_W`, 2: number of condition flags (carry, zero).
- `CTRL_IDLE`, 16'h6E3E: control word driven in reset and halt; all active-low strobes are inactive.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: synchronous reset, active-high despite the name; sampled on `clk`.
- `instruction_register` in OPCODE_W: current opcode.
- `flags` in FLAG_W: ALU condition flags, sampled the same cycle they are used.
- `halt` in 1: stall request.
- `ucode_we` in 1: microcode write strobe.
- `ucode_waddr` in OPCODE_W+STEP_W: write address, `{opcode, step}`.
- `ucode_wdata` in UW: microcode word, where UW = CTRL_W+STEP_W+FSEL_W+2 and FSEL_W = max(1,$clog2(FLAG_W)).
- `ctrl_word` out CTRL_W: registered control word.
- `step` out STEP_W: current step (the counter).
- `instr_done` out 1: registered pulse, aligned with the last step's `ctrl_word`.

## Operation
- **Microcode word layout**, MSB to LSB: `{end, br_en, br_sel[FSEL_W], br_tgt[STEP_W], ctrl[CTRL_W]}`.
- **Read address:** `{instruction_register, step}`. The read is combinational from the store. Fetch steps are programmed identically under every opcode.
- **Step update each cycle, in priority order:**
  1. `rstn`: step <= 0.
  2. `halt`: step holds.
  3. `end`, or step == 2^STEP_W-1: step <= 0.
  4. `br_en` && `flags[br_sel]`: step <= `br_tgt`.
  5. Otherwise: step <= step+1, with no overflow beyond the terminal case in 3.
- **ctrl_word** <= `rstn`||`halt` ? CTRL_IDLE : `ctrl` field of the current word.
- **instr_done** <= !`rstn` && !`halt` && (`end` || step == max).
- **Branch vs end:** if `end` and a taken branch coincide, `end` wins.
- **Branch to the current step** is legal; it behaves as a wait loop on the flag.
- **Writes:** a write with `ucode_we` lands at the rising edge. A read of the same address in the same cycle returns the old word. Writes are accepted during `rstn` and `halt`.
- **Memory reset:** the store is not reset, and its contents are retained across `rstn`. Unwritten locations are X; the bench must load every location before releasing reset.

## Timing
- **Reset values:** `step`=0, `ctrl_word`=CTRL_IDLE, `instr_done`=0, all one cycle after `rstn` is sampled high.
- **Latency:** `ctrl_word` lags its address by one cycle. `step` at cycle n selects the word seen on `ctrl_word` at cycle n+1.
- **instr_done** is high for exactly one cycle per completed instruction. It is never asserted while halted.
- **Halt mid-instruction:** the step is frozen and `ctrl_word`=CTRL_IDLE. On release, execution resumes at the frozen step.
- **Reset mid-instruction:** the instruction is abandoned; the next cycle starts at step 0.

## Configuration
- **`MICROSEQ_BRANCH_EN` defined:** conditional branching behaves as described above.
- **`MICROSEQ_BRANCH_EN` undefined:**
  - `br_en`, `br_sel` and `br_tgt` are still stored but ignored, and `flags` is unused.
  - The step only increments or terminates. This reproduces the plain linear sequencer.

## Structure
- **`microseq_pkg`** holds:
  - field-position localparams (END_BIT, BREN_BIT, BRSEL_LSB, BRTGT_LSB);
  - the UW/FSEL_W derivation functions;
  - the default CTRL_IDLE;
  - named control-bit indices (counter reset, enable-source field, add_sub, ram read/write, pc inc/clr/load, load out/mar/ir/b/a).
- **`microcode_store`** is a sub-module: a 2^(OPCODE_W+STEP_W) × UW array with a synchronous write port and a combinational read port. The sequencer logic lives in the top.

## Test plan
- **Reset:** hold `rstn`=1 for 3 cycles → `ctrl_word`=16'h6E3E, `step`=0, `instr_done`=0. Release → `step` goes 0,1,2…
- **Linear instruction:** opcode 4'h1 with `end` on step 4 → `step` 0..4 then 0. `instr_done` is high exactly one cycle, with `ctrl_word` = the step-4 ctrl.
- **Branch:** opcode 4'h7, step 3 has `br_en`=1, `br_sel`=1, `br_tgt`=6. With `flags`=2'b10, step goes 3→6. With `flags`=2'b00, step goes 3→4. Without `MICROSEQ_BRANCH_EN`, 3→4 in both cases.
- **Halt:** assert `halt` for 2 cycles at step 2 → step stays 2, `ctrl_word`=CTRL_IDLE, no `instr_done`. After release, the step-2 ctrl appears.
- **Wrap and priority:** no `end` bit anywhere → step 7→0 with `instr_done`. `end` and a taken branch on the same step → step 0.
- **Write collision and reset:** write to {4'h2,3'd1} while reading that address → old ctrl is output this cycle and new ctrl on the next visit. `rstn` pulsed at step 5 → next step 0, memory intact.
